// File: rtl/dual_core_dmem_arbiter_if.sv
// Core-side request/response ports and the shared data memory port
// of the dual-core data memory arbiter.
interface dual_core_dmem_arbiter_if #(
  parameter int addr_width = 12,
  parameter int data_width = 12,
  parameter int cnt_width  = 16
);
  logic                  req1;
  logic                  we1;
  logic [addr_width-1:0] addr1;
  logic [data_width-1:0] wdata1;
  logic                  ack1;
  logic [data_width-1:0] rdata1;

  logic                  req2;
  logic                  we2;
  logic [addr_width-1:0] addr2;
  logic [data_width-1:0] wdata2;
  logic                  ack2;
  logic [data_width-1:0] rdata2;

  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_wdata;
  logic                  mem_wren;
  logic [data_width-1:0] mem_q;

  logic                  busy;
  logic                  grant_id;
  logic [cnt_width-1:0]  contention_count;

  modport slave (
    input  req1, we1, addr1, wdata1,
    input  req2, we2, addr2, wdata2,
    input  mem_q,
    output ack1, rdata1, ack2, rdata2,
    output mem_addr, mem_wdata, mem_wren,
    output busy, grant_id, contention_count
  );

  modport master (
    output req1, we1, addr1, wdata1,
    output req2, we2, addr2, wdata2,
    output mem_q,
    input  ack1, rdata1, ack2, rdata2,
    input  mem_addr, mem_wdata, mem_wren,
    input  busy, grant_id, contention_count
  );
endinterface

// File: rtl/dual_core_dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory
// between two cores; one access per four cycles.
module dual_core_dmem_arbiter #(
  parameter int addr_width = 12,
  parameter int data_width = 12,
  parameter int cnt_width  = 16
) (
  input logic clk,
  input logic reset,
  dual_core_dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESPOND
  } state_t;

  localparam logic [cnt_width-1:0] cnt_max = '1;

  state_t state, state_n;

  logic                  gid_q, gid_n;
  logic                  last_q, last_n;
  logic                  we_q, we_n;
  logic [addr_width-1:0] addr_q, addr_n;
  logic [data_width-1:0] wdata_q, wdata_n;
  logic                  wren_q, wren_n;
  logic                  ack1_q, ack1_n;
  logic                  ack2_q, ack2_n;
  logic [data_width-1:0] rd1_q, rd1_n;
  logic [data_width-1:0] rd2_q, rd2_n;
  logic                  busy_q, busy_n;
  logic [cnt_width-1:0]  cnt_q, cnt_n;

  logic both;
  logic pick;

  // last_q=1 means core2 won last, so a tie goes to core1
  assign both = bus.req1 & bus.req2;
  assign pick = both ? ~last_q : bus.req2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      ack1_q  <= 1'b0;
      ack2_q  <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      gid_q   <= gid_n;
      last_q  <= last_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      wren_q  <= wren_n;
      ack1_q  <= ack1_n;
      ack2_q  <= ack2_n;
      rd1_q   <= rd1_n;
      rd2_q   <= rd2_n;
      busy_q  <= busy_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gid_n   = gid_q;
    last_n  = last_q;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    wren_n  = 1'b0;
    ack1_n  = 1'b0;
    ack2_n  = 1'b0;
    rd1_n   = rd1_q;
    rd2_n   = rd2_q;
    cnt_n   = cnt_q;
    unique case (state)
      IDLE: begin
        if (both && cnt_q != cnt_max)
          cnt_n = cnt_q + 1'b1;
        if (bus.req1 || bus.req2) begin
          state_n = ISSUE;
          gid_n   = pick;
          last_n  = pick;
          we_n    = pick ? bus.we2 : bus.we1;
          wren_n  = pick ? bus.we2 : bus.we1;
          addr_n  = pick ? bus.addr2 : bus.addr1;
          wdata_n = pick ? bus.wdata2 : bus.wdata1;
        end
      end
      ISSUE: begin
        state_n = CAPTURE;
      end
      CAPTURE: begin
        // registered read data lands this cycle
        if (!we_q) begin
          if (gid_q)
            rd2_n = bus.mem_q;
          else
            rd1_n = bus.mem_q;
        end
        ack1_n  = ~gid_q;
        ack2_n  = gid_q;
        state_n = RESPOND;
      end
      RESPOND: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy_n = (state_n != IDLE);

  assign bus.ack1             = ack1_q;
  assign bus.ack2             = ack2_q;
  assign bus.rdata1           = rd1_q;
  assign bus.rdata2           = rd2_q;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_wdata        = wdata_q;
  assign bus.mem_wren         = wren_q;
  assign bus.busy             = busy_q;
  assign bus.grant_id         = gid_q;
  assign bus.contention_count = cnt_q;

endmodule

// File: tb/tb_dual_core_dmem_arbiter.sv
// Directed scoreboard bench for the dual-core data memory arbiter,
// plus a narrow-counter instance for contention saturation.
module tb_dual_core_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_s = 1'b1;
  always #5 clk = ~clk;

  dual_core_dmem_arbiter_if #(
    .addr_width(AW), .data_width(DW), .cnt_width(CW)
  ) bus ();
  dual_core_dmem_arbiter_if #(
    .addr_width(AW), .data_width(DW), .cnt_width(4)
  ) sbus ();

  dual_core_dmem_arbiter #(
    .addr_width(AW), .data_width(DW), .cnt_width(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  dual_core_dmem_arbiter #(
    .addr_width(AW), .data_width(DW), .cnt_width(4)
  ) dut_s (
    .clk(clk), .reset(reset_s), .bus(sbus.slave)
  );

  logic [DW-1:0] mem [0:4095] = '{default: '0};
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_addr] <= pre_data;
    else if (bus.mem_wren)
      mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_q <= mem[bus.mem_addr];
  end

  typedef struct packed {
    logic          port;
    logic          load;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [0:4095];
  logic [DW-1:0] exp_r1, exp_r2;
  int            vec = 0;
  int            bad = 0;
  int            wren_cnt = 0;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void expect_txn(input bit port, input bit we,
                                     input logic [AW-1:0] a,
                                     input logic [DW-1:0] d);
    exp_t e;
    if (we) model[a] = d;
    e.port = port;
    e.load = ~we;
    e.data = we ? '0 : model[a];
    sb.push_back(e);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_r1 = '0;
        exp_r2 = '0;
      end else begin
        if (bus.mem_wren) begin
          wren_cnt++;
          w_addr = bus.mem_addr;
          w_data = bus.mem_wdata;
        end
        if (bus.ack1 || bus.ack2) begin
          chk("ack_overlap", 32'(bus.ack1 & bus.ack2), 0);
          if (sb.size() == 0) begin
            chk("unexpected_ack", {30'b0, bus.ack2, bus.ack1}, 0);
          end else begin
            e = sb.pop_front();
            chk("ack_port", 32'(bus.ack2), 32'(e.port));
            chk("grant_id", 32'(bus.grant_id), 32'(e.port));
            if (e.load && e.port) exp_r2 = e.data;
            if (e.load && !e.port) exp_r1 = e.data;
            chk("rdata1", 32'(bus.rdata1), 32'(exp_r1));
            chk("rdata2", 32'(bus.rdata2), 32'(exp_r2));
          end
        end
      end
    end
  endtask

  task automatic core(input bit port, input bit we,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      input int lat_exp, input string tag);
    int n = 0;
    @(posedge clk); #1;
    if (port) begin
      bus.req2 = 1'b1; bus.we2 = we;
      bus.addr2 = a; bus.wdata2 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we;
      bus.addr1 = a; bus.wdata1 = d;
    end
    @(negedge clk);
    while (!(port ? bus.ack2 : bus.ack1) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(n < 50), 1);
    if (lat_exp >= 0) chk({tag, "_lat"}, n, lat_exp);
    @(posedge clk); #1;
    if (port) bus.req2 = 1'b0;
    else bus.req1 = 1'b0;
  endtask

  task automatic reset_vals();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ack", {30'b0, bus.ack2, bus.ack1}, 0);
    chk("rst_wren", 32'(bus.mem_wren), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rdata1", 32'(bus.rdata1), 0);
    chk("rst_rdata2", 32'(bus.rdata2), 0);
    chk("rst_grant", 32'(bus.grant_id), 0);
    chk("rst_count", 32'(bus.contention_count), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.req1 = 1'b0;
    bus.req2 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    reset_vals();
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 4096; i++) model[i] = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.req2 = 0; bus.we2 = 0; bus.addr2 = '0; bus.wdata2 = '0;
    sbus.req1 = 0; sbus.we1 = 0; sbus.addr1 = '0; sbus.wdata1 = '0;
    sbus.req2 = 0; sbus.we2 = 0; sbus.addr2 = '0; sbus.wdata2 = '0;
    sbus.mem_q = '0;
    fork monitor(); join_none

    pre_addr = 12'h005; pre_data = 12'hABC; pre_we = 1'b1;
    model[12'h005] = 12'hABC;
    @(posedge clk); #1;
    pre_we = 1'b0;

    do_reset();

    // core1 load, memory port timing
    expect_txn(0, 0, 12'h005, '0);
    fork
      core(0, 0, 12'h005, '0, 3, "c1_load");
      begin
        @(posedge clk); #1;
        @(negedge clk);
        @(negedge clk);
        chk("c1_addr", 32'(bus.mem_addr), 32'h005);
        chk("c1_wren", 32'(bus.mem_wren), 0);
        chk("c1_busy", 32'(bus.busy), 1);
      end
    join

    // core2 store then load back
    w0 = wren_cnt;
    expect_txn(1, 1, 12'h010, 12'h123);
    core(1, 1, 12'h010, 12'h123, 3, "c2_store");
    chk("st_wren_cycles", wren_cnt - w0, 1);
    chk("st_addr", 32'(w_addr), 32'h010);
    chk("st_wdata", 32'(w_data), 32'h123);
    expect_txn(1, 0, 12'h010, '0);
    core(1, 0, 12'h010, '0, 3, "c2_load");

    // simultaneous requests after reset
    do_reset();
    expect_txn(0, 0, 12'h005, '0);
    expect_txn(1, 0, 12'h010, '0);
    fork
      core(0, 0, 12'h005, '0, 3, "tie_c1");
      core(1, 0, 12'h010, '0, 7, "tie_c2");
    join
    chk("tie_count", 32'(bus.contention_count), 1);

    // back-to-back requests from both cores
    w0 = wren_cnt;
    expect_txn(0, 0, 12'h005, '0);
    expect_txn(1, 0, 12'h010, '0);
    expect_txn(0, 1, 12'h030, 12'h456);
    expect_txn(1, 0, 12'h030, '0);
    fork
      begin
        core(0, 0, 12'h005, '0, -1, "rr_c1a");
        core(0, 1, 12'h030, 12'h456, -1, "rr_c1b");
      end
      begin
        core(1, 0, 12'h010, '0, -1, "rr_c2a");
        core(1, 0, 12'h030, '0, -1, "rr_c2b");
      end
    join
    chk("rr_wren_cycles", wren_cnt - w0, 1);
    chk("rr_count", 32'(bus.contention_count), 2);

    // reset during CAPTURE of a core1 store
    @(posedge clk); #1;
    bus.req1 = 1'b1; bus.we1 = 1'b1;
    bus.addr1 = 12'h020; bus.wdata1 = 12'h777;
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    bus.req1 = 1'b0;
    model[12'h020] = 12'h777;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_ack1", 32'(bus.ack1), 0);
    chk("mid_wren", 32'(bus.mem_wren), 0);
    chk("mid_busy_after", 32'(bus.busy), 0);
    chk("mid_count", 32'(bus.contention_count), 0);
    expect_txn(0, 0, 12'h020, '0);
    core(0, 0, 12'h020, '0, 3, "post_rst");

    // narrow counter: both requests held high permanently
    @(posedge clk); #1;
    sbus.req1 = 1'b1;
    sbus.req2 = 1'b1;
    reset_s = 1'b0;
    repeat (20) @(negedge clk);
    chk("sat_partial", 32'(sbus.contention_count), 5);
    repeat (80) @(negedge clk);
    chk("sat_full", 32'(sbus.contention_count), 15);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/dual_core_dmem_arbiter.md
Name: dual_core_dmem_arbiter

Overview:
- Round-robin arbiter between core1 and core2 of the dual-core processor and one shared single-port data memory.
- Each core posts one load or store request at a time and holds it until acknowledged.
- The arbiter serialises the requests onto the memory port, captures read data, and returns it to the owning core.
- Replaces the direct core1-only address connection to the single-port data memory; works with any memory that has a 1-cycle registered read.

Parameters:
- addr_width, 12, data memory address width (4096 words).
- data_width, 12, memory word width (= reg_width).
- cnt_width, 16, width of the contention counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req1  input  1  core1 request; held high until ack1.
- we1  input  1  core1 store (1) or load (0); stable while req1 is high.
- addr1  input  addr_width  core1 address (AR_to_mem1).
- wdata1  input  data_width  core1 store data (DR_out1).
- req2, we2, addr2, wdata2  input  1/1/addr_width/data_width  core2 equivalents.
- ack1, ack2  output  1  one-cycle completion pulse per port.
- rdata1, rdata2  output  data_width  load result per port; held until that port's next load completes.
- mem_addr  output  addr_width  to memory address.
- mem_wdata  output  data_width  to memory data.
- mem_wren  output  1  to memory wren.
- mem_q  input  data_width  memory read data, valid 1 cycle after address is presented.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  1  0 = core1 owns the transaction, 1 = core2; held from ISSUE through RESPOND.
- contention_count  output  cnt_width  count of IDLE cycles with both requests high; saturates.

Behaviour:
- Reset (synchronous, when reset=1 at a clock edge):
  - state=IDLE.
  - ack1=ack2=0, mem_wren=0, mem_addr=0, mem_wdata=0, rdata1=rdata2=0, grant_id=0, busy=0, contention_count=0.
  - Priority pointer set to prefer core1.
- FSM, all outputs registered:
  - IDLE: if any req is high, latch the winner's addr/wdata/we into mem_* and set grant_id; go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): mem_addr/mem_wdata valid; mem_wren=we of the winner. Go to CAPTURE.
  - CAPTURE (1 cycle): mem_wren=0. For a load, register mem_q into rdata of the granted port at the end of this cycle. Go to RESPOND.
  - RESPOND (1 cycle): ack of the granted port = 1; the other ack = 0. Go to IDLE.
- Latency: req sampled high in IDLE at cycle 0 → mem_wren/mem_addr in cycle 1 → ack high in cycle 3, with rdata valid in the same cycle. Throughput is one access per 4 cycles.
- Arbitration:
  - A single requester is always granted.
  - If both requests are high in IDLE, grant the port NOT granted last; pointer after reset favours core1.
  - Pointer updates on every grant.
- Handshake:
  - A core deasserts req the cycle after it sees ack.
  - The arbiter never samples req during ISSUE, CAPTURE or RESPOND, so a held req cannot double-issue.
  - A req that drops before ack is a protocol violation; the transaction still completes and ack still pulses.
- mem_wren is high for exactly one cycle per store and never for loads.
- rdata of the non-granted port and of a store transaction are unchanged.
- contention_count increments by 1 in each IDLE cycle with req1=req2=1 and holds at 2^cnt_width-1.
- Reset mid-transaction: the next edge forces IDLE and all reset values. A pending ack is lost and mem_wren drops. Cores are reset by the same signal.
- Addresses wrap naturally at addr_width; no range checks.

Test Plan:
- Reset, then core1 load addr1=12'h005 with memory preloaded M[5]=12'hABC → mem_addr=5, mem_wren=0 in cycle 1; ack1 in cycle 3 with rdata1=12'hABC; ack2 stays 0.
- Core2 store addr2=12'h010, wdata2=12'h123 → mem_wren high exactly one cycle with mem_addr=16 and mem_wdata=12'h123; ack2 in cycle 3. A following core2 load of 16 returns 12'h123.
- req1 and req2 rise together after reset → core1 granted first (grant_id=0), core2 second (grant_id=1, ack2 at cycle 7); contention_count=1.
- Both cores request continuously for 4 transactions → grants alternate 1,2,1,2; no ack overlap; rdata1 unchanged by core2 loads.
- Assert reset during CAPTURE of a core1 store → no ack1, mem_wren=0, busy=0 the cycle after reset; a new request after reset completes normally.
- Hold both requests high for 70000 IDLE-contention events (cnt_width=16) → contention_count saturates at 16'hFFFF.
